gcd8_sync_core: RTL and testbench

//  Clocked GCD engine presenting the circuit side of the Balsa gcd8 four-phase bundled-data interface.
//  - Passive on activate.
//  - Active pull on x and y: it requests and the environment supplies data, then acks.
//  - Active push on z: it drives data and req, and the environment acks.

---
 rtl/gcd8_sync_core_if.sv | 29 ++
 rtl/gcd8_sync_core.sv | 161 ++++++++++++++++
 tb/tb_gcd8_sync_core.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd8_sync_core_if.sv
// Four-phase bundled-data channel bundle for gcd8_sync_core: passive activate,
// active pulls on x and y, active push on z.
interface gcd8_sync_core_if #(
  parameter int WIDTH = 8
);
  logic             activate_0r;
  logic             activate_0a;
  logic             x_0r;
  logic             x_0a;
  logic [WIDTH-1:0] x_0d;
  logic             y_0r;
  logic             y_0a;
  logic [WIDTH-1:0] y_0d;
  logic             z_0r;
  logic             z_0a;
  logic [WIDTH-1:0] z_0d;

  // Handshake environment side
  modport master (
    output activate_0r, x_0a, x_0d, y_0a, y_0d, z_0a,
    input  activate_0a, x_0r, y_0r, z_0r, z_0d
  );

  // Core side
  modport slave (
    input  activate_0r, x_0a, x_0d, y_0a, y_0d, z_0a,
    output activate_0a, x_0r, y_0r, z_0r, z_0d
  );
endinterface

// File: rtl/gcd8_sync_core.sv
// Clocked subtractive GCD engine behind the Balsa gcd8 four-phase handshake.
// Optional feature macro GCD8_SYNC_IN_EN: two-flop synchronisers on activate_0r and all acks.
module gcd8_sync_core #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            initialise_n,
  gcd8_sync_core_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    REQ_X = 4'd1,
    RTZ_X = 4'd2,
    REQ_Y = 4'd3,
    RTZ_Y = 4'd4,
    CALC  = 4'd5,
    PUSH  = 4'd6,
    RTZ_Z = 4'd7,
    ACK_A = 4'd8
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  logic [WIDTH-1:0] xr_r;
  logic [WIDTH-1:0] yr_r;
  logic [WIDTH-1:0] z_r;
  logic             x_req_r;
  logic             y_req_r;
  logic             z_req_r;
  logic             act_ack_r;

  logic             act_s;
  logic             x_ack_s;
  logic             y_ack_s;
  logic             z_ack_s;
  logic             has_zero_s;

`ifdef GCD8_SYNC_IN_EN
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;

  // Two-flop synchroniser for activate and the three acks
  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {bus.activate_0r, bus.x_0a, bus.y_0a, bus.z_0a};
      sync2_r <= sync1_r;
    end
  end

  assign {act_s, x_ack_s, y_ack_s, z_ack_s} = sync2_r;
`else
  assign {act_s, x_ack_s, y_ack_s, z_ack_s} = {bus.activate_0r, bus.x_0a, bus.y_0a, bus.z_0a};
`endif

  assign has_zero_s      = (xr_r == ZERO) || (yr_r == ZERO);

  assign bus.activate_0a = act_ack_r;
  assign bus.x_0r        = x_req_r;
  assign bus.y_0r        = y_req_r;
  assign bus.z_0r        = z_req_r;
  assign bus.z_0d        = z_r;

  // Handshake sequencer and GCD datapath; each req is raised only once its ack is seen low
  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n) begin
      state_r   <= IDLE;
      xr_r      <= ZERO;
      yr_r      <= ZERO;
      z_r       <= ZERO;
      x_req_r   <= 1'b0;
      y_req_r   <= 1'b0;
      z_req_r   <= 1'b0;
      act_ack_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (act_s && !x_ack_s) begin
            x_req_r <= 1'b1;
            state_r <= REQ_X;
          end
        end
        REQ_X: begin
          if (x_ack_s) begin
            xr_r    <= bus.x_0d;
            x_req_r <= 1'b0;
            state_r <= RTZ_X;
          end
        end
        RTZ_X: begin
          if (!x_ack_s && !y_ack_s) begin
            y_req_r <= 1'b1;
            state_r <= REQ_Y;
          end
        end
        REQ_Y: begin
          if (y_ack_s) begin
            yr_r    <= bus.y_0d;
            y_req_r <= 1'b0;
            state_r <= RTZ_Y;
          end
        end
        RTZ_Y: begin
          if (!y_ack_s && !z_ack_s) begin
            state_r <= CALC;
          end
        end
        CALC: begin
          // One subtraction per cycle; a zero operand or equality terminates
          if (has_zero_s || (xr_r == yr_r)) begin
            z_r     <= has_zero_s ? (xr_r | yr_r) : xr_r;
            z_req_r <= 1'b1;
            state_r <= PUSH;
          end else if (xr_r > yr_r) begin
            xr_r <= xr_r - yr_r;
          end else begin
            yr_r <= yr_r - xr_r;
          end
        end
        PUSH: begin
          if (z_ack_s) begin
            z_req_r <= 1'b0;
            state_r <= RTZ_Z;
          end
        end
        RTZ_Z: begin
          // Activation is only re-examined here, once the result handshake completes
          if (!z_ack_s) begin
            if (act_s) begin
              if (!x_ack_s) begin
                x_req_r <= 1'b1;
                state_r <= REQ_X;
              end
            end else begin
              act_ack_r <= 1'b1;
              state_r   <= ACK_A;
            end
          end
        end
        ACK_A: begin
          if (!act_s) begin
            act_ack_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          x_req_r   <= 1'b0;
          y_req_r   <= 1'b0;
          z_req_r   <= 1'b0;
          act_ack_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd8_sync_core.sv
// Self-checking bench for gcd8_sync_core: a four-phase environment model plus a
// Euclid-based reference for result value and CALC latency.
module tb_gcd8_sync_core;
  localparam int WIDTH = 8;
`ifdef GCD8_SYNC_IN_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic initialise_n = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   viol    = 0;
  logic z_hold  = 1'b0;
  logic [7:0] z_hold_val = 8'd0;
  logic px = 1'b0, py = 1'b0, pz = 1'b0;

  always #5 clk = ~clk;

  gcd8_sync_core_if #(.WIDTH(WIDTH)) bus ();

  gcd8_sync_core #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .initialise_n (initialise_n),
    .bus          (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol watchdog: exclusive pulls, no req rising over a high ack, z_0d held while pushed
  always @(negedge clk) begin
    viol <= viol
          + ((bus.x_0r === 1'b1 && bus.y_0r === 1'b1) ? 1 : 0)
          + ((bus.x_0r === 1'b1 && px !== 1'b1 && bus.x_0a === 1'b1) ? 1 : 0)
          + ((bus.y_0r === 1'b1 && py !== 1'b1 && bus.y_0a === 1'b1) ? 1 : 0)
          + ((bus.z_0r === 1'b1 && pz !== 1'b1 && bus.z_0a === 1'b1) ? 1 : 0)
          + ((z_hold === 1'b1 && bus.z_0d !== z_hold_val) ? 1 : 0);
    px <= bus.x_0r;
    py <= bus.y_0r;
    pz <= bus.z_0r;
  end

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtraction count of the subtractive algorithm = sum of Euclid quotients minus one
  function automatic int ref_subs(input int a, input int b);
    int q, t;
    if (a == 0 || b == 0) return 0;
    q = 0;
    while (b != 0) begin
      q = q + a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return q - 1;
  endfunction

  task automatic drive_after(input int d);
    repeat (d + 1) @(posedge clk);
    #1;
  endtask

  task automatic wait_cond(input int sel, input logic val, output bit ok);
    logic cur;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      case (sel)
        0:       cur = bus.x_0r;
        1:       cur = bus.y_0r;
        2:       cur = bus.z_0r;
        3:       cur = bus.activate_0a;
        default: cur = 1'b0;
      endcase
      if (cur === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input logic [7:0] x, input logic [7:0] y, input int d,
                        input bit drop_act, input bit stop_at_push,
                        output logic [7:0] z, output int lat, output bit ok);
    int t0;
    z   = 8'd0;
    lat = 0;
    wait_cond(0, 1'b1, ok); if (!ok) return;
    drive_after(d); bus.x_0d = x; bus.x_0a = 1'b1;
    wait_cond(0, 1'b0, ok); if (!ok) return;
    drive_after(d); bus.x_0a = 1'b0; bus.x_0d = 8'($urandom);
    wait_cond(1, 1'b1, ok); if (!ok) return;
    drive_after(d); bus.y_0d = y; bus.y_0a = 1'b1;
    wait_cond(1, 1'b0, ok); if (!ok) return;
    drive_after(d); bus.y_0a = 1'b0; bus.y_0d = 8'($urandom);
    t0 = cyc;
    if (drop_act) begin
      drive_after(3);
      bus.activate_0r = 1'b0;
    end
    wait_cond(2, 1'b1, ok); if (!ok) return;
    lat        = cyc - t0;
    z          = bus.z_0d;
    z_hold_val = z;
    z_hold     = 1'b1;
    if (stop_at_push) return;
    drive_after(d); bus.z_0a = 1'b1;
    wait_cond(2, 1'b0, ok); if (!ok) return;
    drive_after(d); bus.z_0a = 1'b0;
    z_hold = 1'b0;
  endtask

  task automatic test_reset();
    bus.activate_0r = 1'b0;
    bus.x_0a = 1'b0; bus.x_0d = 8'd0;
    bus.y_0a = 1'b0; bus.y_0d = 8'd0;
    bus.z_0a = 1'b0;
    #2 initialise_n = 1'b0;
    #20;
    vectors++; if (bus.activate_0a !== 1'b0) begin errors++; $display("FAIL reset_act_ack got=%b want=0", bus.activate_0a); end
    vectors++; if (bus.x_0r !== 1'b0) begin errors++; $display("FAIL reset_x_req got=%b want=0", bus.x_0r); end
    vectors++; if (bus.y_0r !== 1'b0) begin errors++; $display("FAIL reset_y_req got=%b want=0", bus.y_0r); end
    vectors++; if (bus.z_0r !== 1'b0) begin errors++; $display("FAIL reset_z_req got=%b want=0", bus.z_0r); end
    vectors++; if (bus.z_0d !== 8'd0) begin errors++; $display("FAIL reset_z_data got=%0d want=0", bus.z_0d); end
    @(negedge clk) initialise_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (bus.x_0r !== 1'b0) begin errors++; $display("FAIL idle_no_x_req got=%b want=0", bus.x_0r); end
  endtask

  task automatic run_pairs(input string name, input int xs[], input int ys[], input int dmin, input int dmax);
    logic [7:0] z;
    int lat, exp_lat;
    bit ok;
    for (int i = 0; i < xs.size(); i++) begin
      do_txn(8'(xs[i]), 8'(ys[i]), $urandom_range(dmax, dmin), 1'b0, 1'b0, z, lat, ok);
      vectors++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL %s_timeout pair=(%0d,%0d) got=no handshake want=completed", name, xs[i], ys[i]);
        return;
      end
      vectors++;
      if (z !== 8'(ref_gcd(xs[i], ys[i]))) begin
        errors++;
        $display("FAIL %s_z pair=(%0d,%0d) got=%0d want=%0d", name, xs[i], ys[i], z, ref_gcd(xs[i], ys[i]));
      end
      exp_lat = SYNC_LAT + 2 + ref_subs(xs[i], ys[i]);
      vectors++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL %s_latency pair=(%0d,%0d) got=%0d want=%0d", name, xs[i], ys[i], lat, exp_lat);
      end
    end
  endtask

  task automatic test_sequence();
    int xs[] = '{13, 5, 12, 16, 1, 4};
    int ys[] = '{5, 13, 16, 12, 4, 1};
    bus.activate_0r = 1'b1;
    run_pairs("sequence", xs, ys, 0, 0);
  endtask

  task automatic test_zeros();
    int xs[] = '{0, 9, 0};
    int ys[] = '{7, 0, 0};
    run_pairs("zeros", xs, ys, 0, 2);
  endtask

  task automatic test_slow_acks();
    int xs[] = '{0, 0, 0};
    int ys[] = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      xs[i] = $urandom_range(255, 1);
      ys[i] = $urandom_range(255, 1);
    end
    run_pairs("slow_acks", xs, ys, 10, 10);
    vectors++; if (viol !== 0) begin errors++; $display("FAIL slow_acks_protocol got=%0d violations want=0", viol); end
  endtask

  task automatic test_random();
    int xs[] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int ys[] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      xs[i] = (i % 3 == 0) ? $urandom_range(15, 0) : $urandom_range(255, 0);
      ys[i] = (i % 4 == 0) ? $urandom_range(15, 0) : $urandom_range(255, 0);
    end
    run_pairs("random", xs, ys, 0, 3);
  endtask

  task automatic test_deactivation();
    logic [7:0] z;
    int lat;
    bit ok;
    do_txn(8'd255, 8'd1, 0, 1'b1, 1'b0, z, lat, ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL deact_timeout got=no handshake want=completed"); return; end
    vectors++; if (z !== 8'd1) begin errors++; $display("FAIL deact_z got=%0d want=1", z); end
    vectors++; if (lat !== SYNC_LAT + 256) begin errors++; $display("FAIL deact_latency got=%0d want=%0d", lat, SYNC_LAT + 256); end
    wait_cond(3, 1'b1, ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL deact_act_ack_rise got=timeout want=1"); end
    wait_cond(3, 1'b0, ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL deact_act_ack_fall got=timeout want=0"); end
    repeat (10) @(negedge clk);
    vectors++; if (bus.x_0r !== 1'b0) begin errors++; $display("FAIL deact_idle_x_req got=%b want=0", bus.x_0r); end
    vectors++; if (bus.activate_0a !== 1'b0) begin errors++; $display("FAIL deact_idle_act_ack got=%b want=0", bus.activate_0a); end
  endtask

  task automatic test_reset_mid_push();
    logic [7:0] z;
    int lat;
    bit ok;
    bus.activate_0r = 1'b1;
    do_txn(8'd13, 8'd5, 0, 1'b0, 1'b1, z, lat, ok);
    z_hold = 1'b0;
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL midpush_reach got=no push want=z_0r high"); return; end
    #2 initialise_n = 1'b0;
    #1;
    vectors++; if (bus.z_0r !== 1'b0) begin errors++; $display("FAIL midpush_async_drop got=%b want=0", bus.z_0r); end
    vectors++; if (bus.z_0d !== 8'd0) begin errors++; $display("FAIL midpush_z_data got=%0d want=0", bus.z_0d); end
    @(negedge clk) initialise_n = 1'b1;
    do_txn(8'd12, 8'd16, 1, 1'b0, 1'b0, z, lat, ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL midpush_restart_timeout got=no handshake want=completed"); return; end
    vectors++; if (z !== 8'd4) begin errors++; $display("FAIL midpush_restart_z got=%0d want=4", z); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_zeros();
    test_random();
    test_slow_acks();
    test_deactivation();
    test_reset_mid_push();
    @(negedge clk);
    vectors++; if (viol !== 0) begin errors++; $display("FAIL protocol_total got=%0d violations want=0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
